// File: rtl/alarm_sequencer.sv
// rtl/alarm_sequencer.sv - alarm ring/snooze/stop/timeout sequencer
// Drives the buzzer and snooze/missed status once current time equals the stored alarm time.
module alarm_sequencer #(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    parameter int MAX_SNOOZE  = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        one_second,
    input  logic        alarm_enable,
    input  logic [15:0] current_time,
    input  logic [15:0] alarm_time,
    input  logic        snooze_button,
    input  logic        stop_button,
    output logic        sound_alarm,
    output logic        snoozing,
    output logic [1:0]  snooze_count,
    output logic        missed_alarm
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2,
        LOCKOUT = 2'd3
    } state_t;

    localparam logic [8:0] RING_LAST   = 9'(RING_SECS - 1);
    localparam logic [8:0] SNOOZE_LAST = 9'(SNOOZE_SECS - 1);
    localparam logic [1:0] SNOOZE_MAX  = 2'(MAX_SNOOZE);

    state_t     state_q, state_d;
    logic [8:0] sec_cnt_q, sec_cnt_d;
    logic [1:0] snooze_cnt_q, snooze_cnt_d;
    logic       missed_q, missed_d;
    logic       snz_q, stp_q;

    logic snz_e, stp_e, match;

    // History resets high so a button held through reset cannot produce an edge.
    assign snz_e = snooze_button & ~snz_q;
    assign stp_e = stop_button & ~stp_q;
    assign match = (current_time == alarm_time);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= LOCKOUT;
            sec_cnt_q    <= 9'd0;
            snooze_cnt_q <= 2'd0;
            missed_q     <= 1'b0;
            snz_q        <= 1'b1;
            stp_q        <= 1'b1;
        end else begin
            state_q      <= state_d;
            sec_cnt_q    <= sec_cnt_d;
            snooze_cnt_q <= snooze_cnt_d;
            missed_q     <= missed_d;
            snz_q        <= snooze_button;
            stp_q        <= stop_button;
        end
    end

    always_comb begin
        state_d      = state_q;
        snooze_cnt_d = snooze_cnt_q;
        missed_d     = missed_q;
        sec_cnt_d    = sec_cnt_q;

        case (state_q)
            IDLE: begin
                if (alarm_enable && match) begin
                    state_d = RINGING;
                end
            end
            RINGING: begin
                if (stp_e || !alarm_enable) begin
                    state_d      = LOCKOUT;
                    snooze_cnt_d = 2'd0;
                end else if (snz_e && (snooze_cnt_q < SNOOZE_MAX)) begin
                    state_d      = SNOOZE;
                    snooze_cnt_d = snooze_cnt_q + 2'd1;
                end else if (one_second && (sec_cnt_q == RING_LAST)) begin
                    state_d      = LOCKOUT;
                    missed_d     = 1'b1;
                    snooze_cnt_d = 2'd0;
                end
            end
            SNOOZE: begin
                if (stp_e) begin
                    state_d      = LOCKOUT;
                    snooze_cnt_d = 2'd0;
                end else if (!alarm_enable) begin
                    state_d      = IDLE;
                    snooze_cnt_d = 2'd0;
                end else if (one_second && (sec_cnt_q == SNOOZE_LAST)) begin
                    state_d = RINGING;
                end
            end
            LOCKOUT: begin
                // Hold off until the matching minute has passed to avoid re-triggering.
                if (!match) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = LOCKOUT;
            end
        endcase

        if (stp_e) begin
            missed_d = 1'b0;
        end

        if (state_d != state_q) begin
            sec_cnt_d = 9'd0;
        end else if (one_second && (state_q == RINGING || state_q == SNOOZE)) begin
            sec_cnt_d = sec_cnt_q + 9'd1;
        end
    end

    assign sound_alarm  = (state_q == RINGING);
    assign snoozing     = (state_q == SNOOZE);
    assign snooze_count = snooze_cnt_q;
    assign missed_alarm = missed_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// tb/tb_alarm_sequencer.sv - directed and randomized checks of alarm_sequencer
// Reference model tracks mode, elapsed seconds and snooze budget from the behavioural rules.
module tb_alarm_sequencer;

    localparam int RING_SECS   = 60;
    localparam int SNOOZE_SECS = 300;
    localparam int MAX_SNOOZE  = 3;

    logic        clock = 1'b0;
    logic        reset;
    logic        one_second;
    logic        alarm_enable;
    logic [15:0] current_time;
    logic [15:0] alarm_time;
    logic        snooze_button;
    logic        stop_button;
    logic        sound_alarm;
    logic        snoozing;
    logic [1:0]  snooze_count;
    logic        missed_alarm;

    int checks = 0;
    int errors = 0;

    alarm_sequencer #(
        .RING_SECS  (RING_SECS),
        .SNOOZE_SECS(SNOOZE_SECS),
        .MAX_SNOOZE (MAX_SNOOZE)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .one_second   (one_second),
        .alarm_enable (alarm_enable),
        .current_time (current_time),
        .alarm_time   (alarm_time),
        .snooze_button(snooze_button),
        .stop_button  (stop_button),
        .sound_alarm  (sound_alarm),
        .snoozing     (snoozing),
        .snooze_count (snooze_count),
        .missed_alarm (missed_alarm)
    );

    always #5 clock = ~clock;

    // Reference model: 0 idle, 1 ringing, 2 snoozed, 3 locked out for the matching minute
    int m_mode = 3;
    int m_elapsed = 0;
    int m_snoozes = 0;
    bit m_missed = 0;
    bit m_prev_snz = 1;
    bit m_prev_stp = 1;

    always @(posedge clock) begin
        int  nmode, nel, nsn;
        bit  nmiss, snz_rise, stp_rise, same_time, tick_sec;
        if (reset) begin
            m_mode <= 3; m_elapsed <= 0; m_snoozes <= 0; m_missed <= 0;
            m_prev_snz <= 1; m_prev_stp <= 1;
        end else begin
            snz_rise  = snooze_button && !m_prev_snz;
            stp_rise  = stop_button && !m_prev_stp;
            same_time = (current_time == alarm_time);
            tick_sec  = one_second;
            nmode = m_mode; nsn = m_snoozes; nmiss = m_missed;
            if (m_mode == 0) begin
                if (alarm_enable && same_time) nmode = 1;
            end else if (m_mode == 1) begin
                if (stp_rise || !alarm_enable) begin nmode = 3; nsn = 0; end
                else if (snz_rise && m_snoozes < MAX_SNOOZE) begin nmode = 2; nsn = m_snoozes + 1; end
                else if (tick_sec && m_elapsed + 1 == RING_SECS) begin nmode = 3; nsn = 0; nmiss = 1; end
            end else if (m_mode == 2) begin
                if (stp_rise) begin nmode = 3; nsn = 0; end
                else if (!alarm_enable) begin nmode = 0; nsn = 0; end
                else if (tick_sec && m_elapsed + 1 == SNOOZE_SECS) nmode = 1;
            end else begin
                if (!same_time) nmode = 0;
            end
            if (stp_rise) nmiss = 0;
            if (nmode != m_mode) nel = 0;
            else if (tick_sec && (m_mode == 1 || m_mode == 2)) nel = m_elapsed + 1;
            else nel = m_elapsed;
            m_mode <= nmode; m_elapsed <= nel; m_snoozes <= nsn; m_missed <= nmiss;
            m_prev_snz <= snooze_button; m_prev_stp <= stop_button;
        end
    end

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic pulse_seconds(input int n);
        for (int i = 0; i < n; i++) begin
            one_second = 1'b1;
            tick();
            one_second = 1'b0;
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; one_second = 1'b0; alarm_enable = 1'b1;
        current_time = 16'h0714; alarm_time = 16'h0715;
        snooze_button = 1'b0; stop_button = 1'b0;
        tick(); tick();
        reset = 1'b0;
        checks++;
        if ({sound_alarm, snoozing, snooze_count, missed_alarm} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 00000", {sound_alarm, snoozing, snooze_count, missed_alarm});
        end
        tick();
    endtask

    task automatic test_ring_latency();
        tick();
        checks++;
        if (sound_alarm !== 1'b0) begin errors++; $display("FAIL pre_match_silent: got %b required 0", sound_alarm); end
        current_time = 16'h0715;
        tick();
        checks++;
        if (sound_alarm !== 1'b1 || snooze_count !== 2'd0) begin
            errors++; $display("FAIL ring_latency: sound %b count %0d required 1 0", sound_alarm, snooze_count);
        end
    endtask

    task automatic test_timeout();
        pulse_seconds(RING_SECS - 1);
        checks++;
        if (sound_alarm !== 1'b1) begin errors++; $display("FAIL ring_before_timeout: got %b required 1", sound_alarm); end
        pulse_seconds(1);
        checks++;
        if (sound_alarm !== 1'b0 || missed_alarm !== 1'b1) begin
            errors++; $display("FAIL timeout: sound %b missed %b required 0 1", sound_alarm, missed_alarm);
        end
        repeat (5) tick();
        checks++;
        if (sound_alarm !== 1'b0) begin errors++; $display("FAIL lockout_silent: got %b required 0", sound_alarm); end
        current_time = 16'h0716; tick();
        stop_button = 1'b1; tick();
        stop_button = 1'b0; tick();
        checks++;
        if (missed_alarm !== 1'b0 || sound_alarm !== 1'b0) begin
            errors++; $display("FAIL stop_clears_missed: missed %b sound %b required 0 0", missed_alarm, sound_alarm);
        end
    endtask

    task automatic test_snooze();
        current_time = 16'h0715; tick();
        for (int k = 1; k <= MAX_SNOOZE; k++) begin
            snooze_button = 1'b1; tick();
            checks++;
            if (snoozing !== 1'b1 || sound_alarm !== 1'b0 || snooze_count !== 2'(k)) begin
                errors++; $display("FAIL snooze_enter_%0d: snz %b sound %b count %0d required 1 0 %0d", k, snoozing, sound_alarm, snooze_count, k);
            end
            snooze_button = 1'b0;
            pulse_seconds(SNOOZE_SECS - 1);
            checks++;
            if (snoozing !== 1'b1) begin errors++; $display("FAIL snooze_hold_%0d: got %b required 1", k, snoozing); end
            pulse_seconds(1);
            checks++;
            if (sound_alarm !== 1'b1 || snooze_count !== 2'(k)) begin
                errors++; $display("FAIL snooze_rering_%0d: sound %b count %0d required 1 %0d", k, sound_alarm, snooze_count, k);
            end
        end
        snooze_button = 1'b1; tick();
        checks++;
        if (sound_alarm !== 1'b1 || snoozing !== 1'b0 || snooze_count !== 2'd3) begin
            errors++; $display("FAIL snooze_limit: sound %b snz %b count %0d required 1 0 3", sound_alarm, snoozing, snooze_count);
        end
        snooze_button = 1'b0;
        stop_button = 1'b1; tick();
        stop_button = 1'b0; tick();
        checks++;
        if (sound_alarm !== 1'b0 || snooze_count !== 2'd0) begin
            errors++; $display("FAIL stop_after_limit: sound %b count %0d required 0 0", sound_alarm, snooze_count);
        end
    endtask

    task automatic test_snooze_stop_same();
        current_time = 16'h0716; tick();
        current_time = 16'h0715; tick();
        snooze_button = 1'b1; stop_button = 1'b1; tick();
        checks++;
        if (sound_alarm !== 1'b0 || snoozing !== 1'b0 || snooze_count !== 2'd0) begin
            errors++; $display("FAIL stop_beats_snooze: sound %b snz %b count %0d required 0 0 0", sound_alarm, snoozing, snooze_count);
        end
        snooze_button = 1'b0; stop_button = 1'b0; tick();
    endtask

    task automatic test_reset_midring();
        current_time = 16'h0716; tick();
        current_time = 16'h0715; tick();
        reset = 1'b1; tick();
        reset = 1'b0;
        checks++;
        if ({sound_alarm, snoozing, snooze_count, missed_alarm} !== 5'b0) begin
            errors++; $display("FAIL reset_midring: got %b required 00000", {sound_alarm, snoozing, snooze_count, missed_alarm});
        end
        repeat (4) tick();
        checks++;
        if (sound_alarm !== 1'b0) begin errors++; $display("FAIL no_rering_after_reset: got %b required 0", sound_alarm); end
        current_time = 16'h0716; tick();
        alarm_time = 16'h0716; tick();
        checks++;
        if (sound_alarm !== 1'b1) begin errors++; $display("FAIL reprogrammed_ring: got %b required 1", sound_alarm); end
        stop_button = 1'b1; tick();
        stop_button = 1'b0; tick();
    endtask

    task automatic test_disable_in_snooze();
        current_time = 16'h0717; tick();
        current_time = 16'h0716; tick();
        snooze_button = 1'b1; tick();
        snooze_button = 1'b0;
        alarm_enable = 1'b0; tick();
        checks++;
        if (snoozing !== 1'b0 || snooze_count !== 2'd0 || sound_alarm !== 1'b0) begin
            errors++; $display("FAIL disable_in_snooze: snz %b count %0d sound %b required 0 0 0", snoozing, snooze_count, sound_alarm);
        end
        pulse_seconds(SNOOZE_SECS + 5);
        checks++;
        if (sound_alarm !== 1'b0) begin errors++; $display("FAIL no_rering_disabled: got %b required 0", sound_alarm); end
        current_time = 16'h0714; tick();
        alarm_enable = 1'b1; tick();
    endtask

    task automatic test_random();
        alarm_time = 16'h0715;
        for (int c = 0; c < 8000; c++) begin
            reset = ($urandom_range(0, 1999) == 0);
            one_second = ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 59) == 0) current_time = ($urandom_range(0, 1) == 0) ? 16'h0715 : 16'h0716;
            if ($urandom_range(0, 299) == 0) alarm_enable = ~alarm_enable;
            if (!alarm_enable && $urandom_range(0, 49) == 0) alarm_enable = 1'b1;
            if ($urandom_range(0, 39) == 0) snooze_button = ~snooze_button;
            if ($urandom_range(0, 149) == 0) stop_button = ~stop_button;
            tick();
            checks++;
            if (sound_alarm !== (m_mode == 1) || snoozing !== (m_mode == 2)) begin
                errors++; $display("FAIL rand_state c=%0d: sound %b snz %b required %b %b", c, sound_alarm, snoozing, (m_mode == 1), (m_mode == 2));
            end
            checks++;
            if (snooze_count !== 2'(m_snoozes) || missed_alarm !== m_missed) begin
                errors++; $display("FAIL rand_status c=%0d: count %0d missed %b required %0d %b", c, snooze_count, missed_alarm, m_snoozes, m_missed);
            end
        end
        reset = 1'b0; one_second = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ring_latency();
        test_timeout();
        test_snooze();
        test_snooze_stop_same();
        test_reset_midring();
        test_disable_in_snooze();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
